// File: rtl/div_pkg.sv
// Shared types and constants for the divide16x8_seq sequential divider.
// The PRE state exists only when DIV_SIGNED_EN is defined.
package div_pkg;

  parameter int unsigned DIVIDEND_W_DEF = 16;
  parameter int unsigned DIVISOR_W_DEF  = 8;

  // Quotient reported for a zero divisor; all ones by definition.
  parameter logic [DIVIDEND_W_DEF-1:0] DBZ_QUOTIENT = '1;

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIN, PRE} div_state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, FIN} div_state_e;
`endif

endpackage

// File: rtl/divide16x8_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// signed_op is present only when DIV_SIGNED_EN is defined.
interface divide16x8_seq_if
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
`ifdef DIV_SIGNED_EN
  logic                  signed_op;

  modport master (
    output start, dividend, divisor, signed_op,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, signed_op,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;

  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, divisor_i};
    // Sign bit of the extended difference tells whether the subtraction fits.
    q_o     = ~trial[DIVISOR_W+1];
    rem_o   = q_o ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/divide16x8_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operation via signed_op (adds a pre-negate cycle).
module divide16x8_seq
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic             clk,
  input logic             rst,
  divide16x8_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  div_by_zero_q, div_by_zero_d;
`ifdef DIV_SIGNED_EN
  logic                  neg_dvd_q, neg_dvd_d;
  logic                  neg_dvs_q, neg_dvs_d;
`endif

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic [DIVISOR_W-1:0]  rem_lo;

  assign rem_lo = rem_q[DIVISOR_W-1:0];

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    rem_d         = rem_q;
    dvs_d         = dvs_q;
    dbz_d         = dbz_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
`ifdef DIV_SIGNED_EN
    neg_dvd_d     = neg_dvd_q;
    neg_dvs_d     = neg_dvs_q;
`endif

    unique case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE; start is not accepted there.
        if (bus.start && !done_q) begin
          if (bus.divisor == '0) begin
            dvd_d   = {DIVIDEND_W{&DBZ_QUOTIENT}};
            rem_d   = {1'b0, bus.dividend[DIVISOR_W-1:0]};
            dbz_d   = 1'b1;
            cnt_d   = '0;
            state_d = FIN;
`ifdef DIV_SIGNED_EN
            neg_dvd_d = 1'b0;
            neg_dvs_d = 1'b0;
`endif
          end else begin
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            busy_d  = 1'b1;
`ifdef DIV_SIGNED_EN
            neg_dvd_d = bus.signed_op & bus.dividend[DIVIDEND_W-1];
            neg_dvs_d = bus.signed_op & bus.divisor[DIVISOR_W-1];
            state_d   = bus.signed_op ? PRE : RUN;
`else
            state_d = RUN;
`endif
          end
        end
      end

`ifdef DIV_SIGNED_EN
      PRE: begin
        busy_d  = 1'b1;
        if (neg_dvd_q) dvd_d = -dvd_q;
        if (neg_dvs_q) dvs_d = -dvs_q;
        state_d = RUN;
      end
`endif

      RUN: begin
        busy_d = 1'b1;
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], step_q};
        rem_d  = step_rem;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end

      FIN: begin
`ifdef DIV_SIGNED_EN
        quotient_d  = (!dbz_q && (neg_dvd_q ^ neg_dvs_q)) ? -dvd_q : dvd_q;
        remainder_d = (!dbz_q && neg_dvd_q) ? -rem_lo : rem_lo;
`else
        quotient_d  = dvd_q;
        remainder_d = rem_lo;
`endif
        div_by_zero_d = dbz_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_dvd_q     <= 1'b0;
      neg_dvs_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      rem_q         <= rem_d;
      dvs_q         <= dvs_d;
      dbz_q         <= dbz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef DIV_SIGNED_EN
      neg_dvd_q     <= neg_dvd_d;
      neg_dvs_q     <= neg_dvs_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule
